button_led_ctrl: RTL and testbench

//  Parametrised successor to the two-button LED control block. Synchronises and

---
 rtl/button_led_ctrl_if.sv | 22 ++
 rtl/button_led_ctrl.sv | 92 +++++++++
 tb/tb_button_led_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/button_led_ctrl_if.sv
// Board-side signal bundle for button_led_ctrl: raw buttons in, LED bank, mode and press pulses out.
// The master side drives the buttons; the slave side is the controller.
interface button_led_ctrl_if #(
  parameter int LED_W = 3
);
  logic             button_0;
  logic             button_1;
  logic             button_2;
  logic [LED_W-1:0] led;
  logic             mode;
  logic [2:0]       press;

  modport master (
    output button_0, button_1, button_2,
    input  led, mode, press
  );

  modport slave (
    input  button_0, button_1, button_2,
    output led, mode, press
  );
endinterface

// File: rtl/button_led_ctrl.sv
// Synchronises and debounces three active-low buttons, emits one-cycle press pulses,
// and drives an LED bank as a binary counter (COUNT) or a rotating one-hot (SHIFT).
module button_led_ctrl #(
  parameter int LED_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input logic              clk,
  input logic              rst_n,
  button_led_ctrl_if.slave bus
);
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_W-1:0]  LED_ONE  = LED_W'(1);

  logic [2:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] sync_d [3];
  logic [CNT_W-1:0]       cnt_q  [3];
  logic [CNT_W-1:0]       cnt_d  [3];
  logic [2:0]             db_q, db_d;
  logic [2:0]             db_prev_q, db_prev_d;
  logic [2:0]             press_q, press_d;
  logic [LED_W-1:0]       led_q, led_d;
  logic                   mode_q, mode_d;

  assign btn_raw = {bus.button_2, bus.button_1, bus.button_0};

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    db_d      = db_q;
    db_prev_d = db_q;
    // Falling edge of the debounced level, registered once more to line up the pulse.
    press_d   = db_prev_q & ~db_q;
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      cnt_d[i]  = '0;
      if (sync_q[i][SYNC_STAGES-1] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    if (press_q[2]) begin
      mode_d = ~mode_q;
      // A blank bank would stay blank forever under rotation, so seed it.
      if (!mode_q && led_q == '0) begin
        led_d = LED_ONE;
      end
    end else if (press_q[0] && !press_q[1]) begin
      led_d = mode_q ? {led_q[LED_W-2:0], led_q[LED_W-1]} : led_q + LED_ONE;
    end else if (press_q[1] && !press_q[0]) begin
      led_d = mode_q ? {led_q[0], led_q[LED_W-1:1]} : led_q - LED_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      db_q      <= '1;
      db_prev_q <= '1;
      press_q   <= '0;
      led_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      led_q     <= led_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.mode  = mode_q;
  assign bus.press = press_q;
endmodule

// File: tb/tb_button_led_ctrl.sv
// Scoreboard bench for button_led_ctrl: each intended press queues its expected pulse
// and the LED/mode state that must follow; a monitor pops and compares on every pulse.
module tb_button_led_ctrl;
  localparam int LED_W = 3;
  localparam int DEB   = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = 1 + SYNC + DEB;

  typedef struct {
    logic [2:0]       press;
    logic [LED_W-1:0] led;
    logic             mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_press_cyc = -1;
  exp_t exp_q[$];
  exp_t pend;
  bit   have_pend = 1'b0;

  button_led_ctrl_if #(.LED_W(LED_W)) bif ();

  button_led_ctrl #(
    .LED_W(LED_W), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (have_pend) begin
      check("led_after_press", 32'(bif.led), 32'(pend.led));
      check("mode_after_press", 32'(bif.mode), 32'(pend.mode));
      have_pend = 1'b0;
    end
    if (bif.press !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_press", 32'(bif.press), 32'd0);
      end else begin
        pend = exp_q.pop_front();
        check("press", 32'(bif.press), 32'(pend.press));
        have_pend      = 1'b1;
        last_press_cyc = cyc;
      end
    end
  end

  task automatic set_buttons(input logic [2:0] lvl);
    bif.button_0 = lvl[0];
    bif.button_1 = lvl[1];
    bif.button_2 = lvl[2];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the buttons in mask, hold, release, and expect one pulse with the given aftermath.
  task automatic press_btn(input logic [2:0] mask, input logic [LED_W-1:0] e_led,
                           input logic e_mode, input int hold);
    exp_t e;
    int   drive_cyc;
    e.press = mask;
    e.led   = e_led;
    e.mode  = e_mode;
    exp_q.push_back(e);
    @(negedge clk);
    last_press_cyc = -1;
    drive_cyc      = cyc;
    set_buttons(~mask);
    wait_cycles(hold);
    set_buttons(3'b111);
    wait_cycles(12);
    check("pulse_seen", 32'(exp_q.size()), 32'd0);
    check("press_latency", 32'(last_press_cyc - drive_cyc), 32'(LAT));
  endtask

  initial begin
    set_buttons(3'b111);
    rst_n = 1'b0;

    // Reset state, then release with buttons idle.
    wait_cycles(3);
    check("rst_led", 32'(bif.led), 32'd0);
    check("rst_mode", 32'(bif.mode), 32'd0);
    check("rst_press", 32'(bif.press), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("post_rst_led", 32'(bif.led), 32'd0);
    check("post_rst_mode", 32'(bif.mode), 32'd0);

    // Single long press: one pulse, no repeat while held or on release.
    press_btn(3'b001, 3'b001, 1'b0, 10);
    check("hold_led", 32'(bif.led), 32'd1);

    // COUNT wrap down and up.
    press_btn(3'b010, 3'b000, 1'b0, 8);
    press_btn(3'b010, 3'b111, 1'b0, 8);
    press_btn(3'b001, 3'b000, 1'b0, 8);
    press_btn(3'b001, 3'b001, 1'b0, 8);
    for (int i = 1; i <= 7; i++) begin
      press_btn(3'b001, LED_W'((1 + i) % 8), 1'b0, 8);
    end
    check("count_wrap_led", 32'(bif.led), 32'd0);

    // Glitches shorter than the debounce window must not register.
    @(negedge clk);
    set_buttons(3'b110);
    wait_cycles(3);
    set_buttons(3'b111);
    wait_cycles(12);
    check("short_led", 32'(bif.led), 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_buttons({2'b11, 1'(i % 2)});
      @(negedge clk);
    end
    set_buttons(3'b111);
    wait_cycles(12);
    check("bounce_led", 32'(bif.led), 32'd0);
    check("bounce_mode", 32'(bif.mode), 32'd0);

    // SHIFT mode: seed, rotate both ways, leave with led kept.
    press_btn(3'b100, 3'b001, 1'b1, 8);
    press_btn(3'b001, 3'b010, 1'b1, 8);
    press_btn(3'b001, 3'b100, 1'b1, 8);
    press_btn(3'b001, 3'b001, 1'b1, 8);
    press_btn(3'b010, 3'b100, 1'b1, 8);
    press_btn(3'b100, 3'b100, 1'b0, 8);

    // Simultaneous increment and decrement cancel out.
    press_btn(3'b011, 3'b100, 1'b0, 8);

    // Button held through a reset pulse yields exactly one press afterwards.
    @(negedge clk);
    set_buttons(3'b110);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_led", 32'(bif.led), 32'd0);
    check("midrst_press", 32'(bif.press), 32'd0);
    begin
      exp_t e;
      e.press = 3'b001;
      e.led   = 3'b001;
      e.mode  = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(15);
    check("held_rst_pulse", 32'(exp_q.size()), 32'd0);
    set_buttons(3'b111);
    wait_cycles(12);
    check("held_rst_led", 32'(bif.led), 32'd1);

    check("drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
